// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdm_pkg
// Description : Shared constants and state encoding for the 8-slot TDM
//               demultiplexer and its slot counter.
// Contents    : N_SLOTS - slots per frame
//               SLOT_W  - width of a slot index
//               state_t - framing FSM states {HUNT, LOCK}
// Revision    : 1.0 - initial release
// ============================================================================
package tdm_pkg;

  localparam int N_SLOTS = 8;
  localparam int SLOT_W  = 3;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/tdm_demux8_if.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux8_if
// Description : Serial TDM input bundle plus the demultiplexed frame outputs.
// Signals     : din, en, fsync            - serial bit, slot strobe, frame mark
//               dout, slot                - last full frame, next slot index
//               frame_valid, sync_err     - single-cycle event pulses
//               locked                    - framing acquired
// Modports    : master - drives the serial side, observes the outputs
//               slave  - the demultiplexer itself
// Revision    : 1.0 - initial release
// ============================================================================
interface tdm_demux8_if;
  import tdm_pkg::*;

  logic                din;
  logic                en;
  logic                fsync;
  logic [N_SLOTS-1:0]  dout;
  logic [SLOT_W-1:0]   slot;
  logic                frame_valid;
  logic                sync_err;
  logic                locked;

  modport master (
    output din, en, fsync,
    input  dout, slot, frame_valid, sync_err, locked
  );

  modport slave (
    input  din, en, fsync,
    output dout, slot, frame_valid, sync_err, locked
  );

endinterface
`default_nettype wire

// File: rtl/tdm_slot_ctr.sv
`default_nettype none
// ============================================================================
// Module      : tdm_slot_ctr
// Description : Slot index counter, wraps modulo N_SLOTS.
// Ports       : clk, rst  - clock, asynchronous active-high reset
//               inc       - advance by one (wrapping)
//               load1     - force the count to 1 (slot 0 just consumed)
//               clr       - force the count to 0
//               cnt       - current slot index (registered)
//               term      - high while cnt is the last slot
// Priority    : clr > load1 > inc
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              inc,
  input  wire logic              load1,
  input  wire logic              clr,
  output      logic [SLOT_W-1:0] cnt,
  output      logic              term
);

  logic [SLOT_W-1:0] cnt_q;
  logic [SLOT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load1) begin
      cnt_d = SLOT_W'(1);
    end else if (inc) begin
      // N_SLOTS is a power of two, so natural overflow gives the 7->0 wrap.
      cnt_d = cnt_q + SLOT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign term = (cnt_q == SLOT_W'(N_SLOTS - 1));

endmodule
`default_nettype wire

// File: rtl/tdm_demux8.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux8
// Description : Serial-to-parallel TDM demultiplexer with frame alignment.
//               One slot is consumed per clock with en=1; a full frame of
//               N_SLOTS bits is published on dout when slot 7 is captured.
// Parameters  : SYNC_CHECK - 1: missing fsync at slot 0 drops lock
//                            0: free-run once locked
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-high reset
//               bus  - tdm_demux8_if.slave (din/en/fsync in, frame outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux8
  import tdm_pkg::*;
#(
  parameter bit SYNC_CHECK = 1'b1
) (
  input wire logic     clk,
  input wire logic     rst,
  tdm_demux8_if.slave  bus
);

  state_t             state_q, state_d;
  logic [N_SLOTS-1:0] shadow_q, shadow_d;
  logic [N_SLOTS-1:0] dout_q, dout_d;
  logic               frame_valid_q, frame_valid_d;
  logic               sync_err_q, sync_err_d;

  logic               ctr_inc;
  logic               ctr_load1;
  logic               ctr_clr;
  logic [SLOT_W-1:0]  slot_cnt;
  logic               slot_term;

  tdm_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (ctr_inc),
    .load1 (ctr_load1),
    .clr   (ctr_clr),
    .cnt   (slot_cnt),
    .term  (slot_term)
  );

  // Next-state / datapath decode. Framing violations are tested before the
  // normal capture path so a slot-7 capture can never coincide with sync_err.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    dout_d        = dout_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    ctr_inc       = 1'b0;
    ctr_load1     = 1'b0;
    ctr_clr       = 1'b0;

    if (bus.en) begin
      case (state_q)
        HUNT: begin
          if (bus.fsync) begin
            shadow_d  = {{(N_SLOTS-1){1'b0}}, bus.din};
            ctr_load1 = 1'b1;
            state_d   = LOCK;
          end
        end

        LOCK: begin
          if (bus.fsync && (slot_cnt != '0)) begin
            // Early frame marker: drop the partial frame and restart at slot 0.
            sync_err_d = 1'b1;
            shadow_d   = {{(N_SLOTS-1){1'b0}}, bus.din};
            ctr_load1  = 1'b1;
          end else if (SYNC_CHECK && !bus.fsync && (slot_cnt == '0)) begin
            // Marker missing where one was due: give up alignment.
            sync_err_d = 1'b1;
            ctr_clr    = 1'b1;
            state_d    = HUNT;
          end else begin
            shadow_d[slot_cnt] = bus.din;
            ctr_inc            = 1'b1;
            if (slot_term) begin
              dout_d        = shadow_d;
              frame_valid_d = 1'b1;
            end
          end
        end

        default: begin
          state_d = HUNT;
          ctr_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      shadow_q      <= '0;
      dout_q        <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      dout_q        <= dout_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign bus.dout        = dout_q;
  assign bus.slot        = slot_cnt;
  assign bus.frame_valid = frame_valid_q;
  assign bus.sync_err    = sync_err_q;
  assign bus.locked      = (state_q == LOCK);

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux8.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdm_demux8
// Description : Self-checking bench for tdm_demux8. Directed vector table,
//               hand-written framing corner cases, and randomized traffic
//               compared against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux8;
  import tdm_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tdm_demux8_if bus ();

  tdm_demux8 #(.SYNC_CHECK(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int fv_cnt  = 0;
  int err_cnt = 0;

  // Reference model: a frame buffer and a position within the frame.
  bit       m_locked;
  int       m_pos;
  bit [7:0] m_bits;
  bit [7:0] m_dout;
  bit       m_fv;
  bit       m_err;

  typedef struct {
    bit       din;
    bit       en;
    bit       fsync;
    bit [7:0] dout;
    bit [2:0] slot;
    bit       fv;
    bit       err;
    bit       lock;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0;
    m_pos    = 0;
    m_bits   = '0;
    m_dout   = '0;
    m_fv     = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic model_step(input bit d, input bit e, input bit f);
    m_fv  = 1'b0;
    m_err = 1'b0;
    if (e) begin
      if (!m_locked) begin
        if (f) begin
          m_bits   = 8'(d);
          m_pos    = 1;
          m_locked = 1'b1;
        end
      end else if (f && m_pos != 0) begin
        m_err  = 1'b1;
        m_bits = 8'(d);
        m_pos  = 1;
      end else if (!f && m_pos == 0) begin
        m_err    = 1'b1;
        m_locked = 1'b0;
      end else begin
        m_bits[m_pos] = d;
        if (m_pos == N_SLOTS - 1) begin
          m_dout = m_bits;
          m_fv   = 1'b1;
        end
        m_pos = (m_pos + 1) % N_SLOTS;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".dout"},   bus.dout,        m_dout);
    chk({tag, ".slot"},   8'(bus.slot),    8'(m_pos));
    chk({tag, ".fvalid"}, 8'(bus.frame_valid), 8'(m_fv));
    chk({tag, ".syncerr"},8'(bus.sync_err),    8'(m_err));
    chk({tag, ".locked"}, 8'(bus.locked),      8'(m_locked));
  endtask

  // One clock: drive on the falling edge, check just after the rising edge.
  task automatic step(input bit d, input bit e, input bit f, input string tag);
    @(negedge clk);
    bus.din   = d;
    bus.en    = e;
    bus.fsync = f;
    model_step(d, e, f);
    @(posedge clk);
    #1;
    if (bus.frame_valid) fv_cnt++;
    if (bus.sync_err)    err_cnt++;
    check_model(tag);
  endtask

  task automatic send_frame(input bit [7:0] v, input bit gap, input bit with_sync, input string tag);
    for (int k = 0; k < N_SLOTS; k++) begin
      step(v[k], 1'b1, with_sync && (k == 0), tag);
      if (gap) step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), tag);
    end
  endtask

  // Reset asserted between clock edges; outputs must clear without a clock.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk({tag, ".rst_dout"},   bus.dout, 8'h00);
    chk({tag, ".rst_slot"},   8'(bus.slot), 8'h00);
    chk({tag, ".rst_fvalid"}, 8'(bus.frame_valid), 8'h00);
    chk({tag, ".rst_syncerr"},8'(bus.sync_err), 8'h00);
    chk({tag, ".rst_locked"}, 8'(bus.locked), 8'h00);
    model_reset();
    bus.en    = 1'b0;
    bus.fsync = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.din   = 1'b0;
    bus.en    = 1'b0;
    bus.fsync = 1'b0;
    rst       = 1'b1;
    model_reset();

    // Frame 1,1,0,1,0,0,0,0 (slot0..7) -> 8'h0B, then an idle hold cycle.
    tbl[0] = '{1'b1, 1'b1, 1'b1, 8'h00, 3'd1, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 8'h00, 3'd4, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd6, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd7, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 8'h0B, 3'd0, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 8'h0B, 3'd0, 1'b0, 1'b0, 1'b1};

    #1;
    chk("init.dout",   bus.dout, 8'h00);
    chk("init.locked", 8'(bus.locked), 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed frame from the vector table.
    fv_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].din, tbl[i].en, tbl[i].fsync, "vec");
      chk("vec.dout",    bus.dout, tbl[i].dout);
      chk("vec.slot",    8'(bus.slot), 8'(tbl[i].slot));
      chk("vec.fvalid",  8'(bus.frame_valid), 8'(tbl[i].fv));
      chk("vec.syncerr", 8'(bus.sync_err), 8'(tbl[i].err));
      chk("vec.locked",  8'(bus.locked), 8'(tbl[i].lock));
    end
    chk("vec.fv_count", 8'(fv_cnt), 8'd1);

    // Two frames with en toggling between slots.
    fv_cnt  = 0;
    err_cnt = 0;
    send_frame(8'hA5, 1'b1, 1'b1, "b2b");
    chk("b2b.first", bus.dout, 8'hA5);
    send_frame(8'h3C, 1'b1, 1'b1, "b2b");
    chk("b2b.second", bus.dout, 8'h3C);
    chk("b2b.fv_count", 8'(fv_cnt), 8'd2);
    chk("b2b.err_count", 8'(err_cnt), 8'd0);

    // Early fsync at slot 4 discards the partial frame.
    fv_cnt  = 0;
    err_cnt = 0;
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, k == 0, "early");
    send_frame(8'hFF, 1'b0, 1'b1, "early");
    chk("early.err_count", 8'(err_cnt), 8'd1);
    chk("early.fv_count",  8'(fv_cnt), 8'd1);
    chk("early.dout",      bus.dout, 8'hFF);

    // Missing fsync at slot 0 drops lock; en pulses then ignored.
    fv_cnt  = 0;
    err_cnt = 0;
    step(1'b1, 1'b1, 1'b0, "miss");
    chk("miss.locked", 8'(bus.locked), 8'h00);
    for (int k = 0; k < 6; k++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, "miss");
    chk("miss.err_count", 8'(err_cnt), 8'd1);
    chk("miss.fv_count",  8'(fv_cnt), 8'd0);
    chk("miss.dout_hold", bus.dout, 8'hFF);
    send_frame(8'h5A, 1'b0, 1'b1, "miss");
    chk("miss.relock_dout", bus.dout, 8'h5A);

    // Reset after slot 5 of a frame.
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1, k == 0, "midrst");
    do_reset("midrst");

    // Hunting: en without fsync does nothing.
    fv_cnt  = 0;
    err_cnt = 0;
    for (int k = 0; k < 20; k++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, "hunt");
    chk("hunt.dout",      bus.dout, 8'h00);
    chk("hunt.fv_count",  8'(fv_cnt), 8'd0);
    chk("hunt.err_count", 8'(err_cnt), 8'd0);
    send_frame(8'h81, 1'b0, 1'b1, "postrst");
    chk("postrst.dout", bus.dout, 8'h81);

    // Randomized traffic; fsync is biased toward landing on frame boundaries.
    for (int n = 0; n < 3000; n++) begin
      bit d, e, f;
      d = 1'($urandom_range(0, 1));
      e = ($urandom_range(0, 3) != 0);
      if (!m_locked)        f = ($urandom_range(0, 3) == 0);
      else if (m_pos == 0)  f = ($urandom_range(0, 7) != 0);
      else                  f = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 599) == 0) do_reset("rnd");
      else step(d, e, f, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/tdm_demux8.md
TDM_DEMUX8 -- requirements
Module: tdm_demux8

Interface
REQ-001 Parameter: SYNC_CHECK, default 1, meaning 1 = a missing sync at an expected slot 0 drops lock; 0 = free-run once locked.
REQ-002 Port: clk  input  1  rising-edge system clock.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: din  input  1  serial TDM data bit, sampled when en=1.
REQ-005 Port: en  input  1  slot strobe; one slot consumed per clk with en=1.
REQ-006 Port: fsync  input  1  frame marker, qualified by en; marks slot 0.
REQ-007 Port: dout  output  8  last complete frame; dout[k] = bit received in slot k.
REQ-008 Port: slot  output  3  index of the next slot to be captured.
REQ-009 Port: frame_valid  output  1  one-cycle pulse when dout updates.
REQ-010 Port: sync_err  output  1  one-cycle pulse on a framing violation.
REQ-011 Port: locked  output  1  high while the FSM is in LOCK.

Function
REQ-012 The FSM has two states, HUNT and LOCK. No state changes and no capture occur on cycles with en=0.
REQ-013 HUNT: en=1 with fsync=0 is ignored. en=1 with fsync=1 captures din into shadow bit 0, sets slot=1, and moves to LOCK.
REQ-014 LOCK: each en=1 captures din into shadow bit [slot] and increments slot modulo 8. Wrap 7->0 is expected.
REQ-015 On capture of slot 7, the full shadow (including the bit just captured) loads into dout on the same edge, and frame_valid=1 for exactly that cycle.
REQ-016 dout holds its value between frame completions. Partial frames never reach dout.
REQ-017 LOCK, en=1, fsync=1, slot!=0: sync_err=1 for one cycle, the partial frame is discarded, din is taken as slot 0, slot=1, and the FSM stays in LOCK.
REQ-018 LOCK, en=1, fsync=0, slot=0, SYNC_CHECK=1: sync_err=1 for one cycle, no capture, slot=0, and the FSM goes to HUNT.
REQ-019 LOCK, en=1, fsync=1, slot=0: normal capture with no error.
REQ-020 Capture at slot 7 and a frame_valid pulse never coincide with sync_err, because REQ-017 and REQ-018 take priority over capture.
REQ-021 Latency is one clk from the slot-7 en edge to dout and frame_valid being visible.
REQ-022 All outputs are registered. No combinational path runs from inputs to outputs.

Reset
REQ-023 While rst=1, regardless of clk: dout=8'h00, shadow=8'h00, slot=0, frame_valid=0, sync_err=0, locked=0, FSM=HUNT.
REQ-024 Reset asserted mid-frame discards the partial frame. After release the block requires a new fsync.
REQ-025 The first en edge after rst deasserts is processed normally.

Structure
REQ-026 Shared package tdm_pkg holds N_SLOTS=8, SLOT_W=3, and the state enum {HUNT, LOCK}.
REQ-027 One sub-module, tdm_slot_ctr, provides the 3-bit slot counter with inc, load-to-1, and clear controls plus a terminal flag at 7. All other logic is inline.

Verification
REQ-028 Reset, then send fsync on slot 0 and bits slot0..7 = 1,1,0,1,0,0,0,0 with en=1 every cycle: dout=8'h0B, one frame_valid, locked=1.
REQ-029 Send two back-to-back frames 8'hA5 then 8'h3C, with en toggling 1,0,1,0 between slots: dout=8'hA5 then 8'h3C, exactly two frame_valid pulses, no sync_err.
REQ-030 While locked, assert fsync at slot 4, then send 8 bits forming 8'hFF: one sync_err, the first partial frame is never output, and dout=8'hFF.
REQ-031 With SYNC_CHECK=1, omit fsync at the next slot 0: one sync_err, locked=0, and en pulses are ignored until fsync returns.
REQ-032 Assert rst after slot 5 of a frame: all outputs are immediately 0 and locked=0. The next full frame 8'h81 with fsync gives dout=8'h81.
REQ-033 In HUNT, send 20 en pulses with fsync=0: dout remains 8'h00, and there is no frame_valid and no sync_err.
